sm_addsub_pipe: RTL and testbench
=================================

// Module: sm_addsub_pipe
// PURPOSE
//  Parametrised, pipelined sign-magnitude adder/subtractor for the FP datapath mantissa stage.
//  Generalises the combinational mantissa add/sub: explicit add/sub op, MAG_W-wide operands,
//  2-stage valid/ready pipeline, +0 canonicalisation, leading-zero count for the normaliser,
//  and a saturating carry-out event counter. Sits between exponent alignment and normalisation.
// PARAMETERS
//  MAG_W   24  operand magnitude width (bits); result is MAG_W+1 bits
//  CNT_W   16  width of saturating carry-event counter
//  LZC_W   $clog2(MAG_W+2)  width of lzc output (derived localparam, not overridable)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  op         in   1        0 = A+B, 1 = A-B
//  sign_a     in   1        sign of A (1 = negative)
//  sign_b     in   1        sign of B
//  a          in   MAG_W    magnitude of A
//  b          in   MAG_W    magnitude of B
//  out_valid  out  1        result beat valid
//  out_ready  in   1        downstream accepts result
//  res        out  MAG_W+1  result magnitude
//  sign_res   out  1        result sign
//  carry      out  1        res[MAG_W]
//  zero       out  1        res == 0
//  lzc        out  LZC_W    leading zeros of res counted from bit MAG_W (MAG_W+1 when res==0)
//  clr_cnt    in   1        synchronous clear of carry_cnt
//  carry_cnt  out  CNT_W    count of accepted output beats with carry=1, saturating
// BEHAVIOUR
//  - Effective sign of B: sb = sign_b ^ op. Input beat accepted when in_valid && in_ready.
//  - Stage 1 (S1): register eff_sub = (sign_a != sb); big/small = operands ordered so big >= small
//    (a >= b -> big=a, sign=sign_a; else big=b, sign=sb). Same signs: sign=sign_a, no swap.
//  - Stage 2 (S2): eff_sub=0 -> res = big + small (MAG_W+1 bits, no overflow possible);
//    eff_sub=1 -> res = big - small (never negative). res==0 -> sign_res forced 0 (+0), always.
//    lzc, zero, carry computed from S2 result and registered with it.
//  - Latency: exactly 2 cycles from acceptance to out_valid when out_ready held high; 1 beat/cycle.
//  - Handshake: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en
//    (combinational from out_ready, allowed). S1 moves into S2 when s1_valid && s2_en.
//    out_valid/res/sign_res/carry/zero/lzc stable while out_valid && !out_ready. No beat dropped
//    or duplicated; order preserved. Simultaneous accept and drain in same cycle is legal.
//  - in_valid with in_ready=0: inputs ignored, upstream must hold.
//  - carry_cnt: +1 on cycle out_valid && out_ready && carry; holds at 2^CNT_W-1.
//    clr_cnt wins over simultaneous increment (result 0).
//  - Reset (async assert, any time incl. mid-flight): s1_valid=s2_valid=0, out_valid=0, res=0,
//    sign_res=0, carry=0, zero=1, lzc=MAG_W+1, carry_cnt=0; in-flight beats discarded.
//    in_ready=1 from first clock after release.
// TESTING (MAG_W=24 unless stated)
//  1 op=0,sign_a=0,sign_b=0,a=b=0x800000 -> 2 cycles later res=0x1000000,sign_res=0,carry=1,lzc=0.
//  2 op=1,sign_a=0,sign_b=0,a=5,b=9 -> res=4,sign_res=1,carry=0,zero=0,lzc=22.
//  3 op=0,sign_a=1,sign_b=0,a=b=0x123456 -> res=0,sign_res=0,zero=1,lzc=25.
//  4 out_ready=0, 4 back-to-back beats -> 2 accepted then in_ready=0; raise out_ready ->
//    all 4 results emerge in order, values unchanged while stalled, none lost.
//  5 rst_n low for 1 cycle with 2 beats in flight -> out_valid=0, no stale result after release.
//  6 CNT_W=2, 5 carry beats then clr_cnt concurrent with a 6th -> carry_cnt 1,2,3,3,3 then 0.

Source files
------------

// File: rtl/sm_addsub_pipe.sv
// Pipelined sign-magnitude adder/subtractor for the FP mantissa stage.
// S1 resolves the effective operation and orders the operands so the
// magnitude datapath never goes negative; S2 does the add/sub and derives
// the flags, leading-zero count and sign, all registered with the result.
module sm_addsub_pipe #(
  parameter int unsigned  MAG_W = 24,
  parameter int unsigned  CNT_W = 16,
  localparam int unsigned LZC_W = $clog2(MAG_W + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [MAG_W-1:0] a,
  input  logic [MAG_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   res,
  output logic             sign_res,
  output logic             carry,
  output logic             zero,
  output logic [LZC_W-1:0] lzc,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  // Pipeline state
  logic             s1_valid_q;
  logic             s1_eff_sub_q;
  logic             s1_sign_q;
  logic [MAG_W-1:0] s1_big_q;
  logic [MAG_W-1:0] s1_small_q;

  logic             s2_valid_q;
  logic [MAG_W:0]   res_q;
  logic             sign_q;
  logic             carry_q;
  logic             zero_q;
  logic [LZC_W-1:0] lzc_q;
  logic [CNT_W-1:0] cnt_q;

  logic s1_en, s2_en, accept, fire;
  logic sb, eff_sub_d, swap;
  logic [MAG_W:0]   sum_d;
  logic [LZC_W-1:0] lzc_d;

  // Handshake: a stage advances when its successor is empty or draining
  always_comb begin
    s2_en  = !s2_valid_q || out_ready;
    s1_en  = !s1_valid_q || s2_en;
    accept = in_valid && s1_en;
    fire   = s2_valid_q && out_ready;
  end

  // Effective op and operand ordering; only a true subtract ever swaps
  always_comb begin
    sb        = sign_b ^ op;
    eff_sub_d = (sign_a != sb);
    swap      = eff_sub_d && (a < b);
  end

  // Stage 1 register: operand beat after ordering
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_big_q     <= '0;
      s1_small_q   <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (accept) begin
        s1_eff_sub_q <= eff_sub_d;
        s1_sign_q    <= swap ? sb : sign_a;
        s1_big_q     <= swap ? b : a;
        s1_small_q   <= swap ? a : b;
      end
    end
  end

  // Magnitude add/sub; big >= small whenever subtracting
  always_comb begin
    if (s1_eff_sub_q) sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
    else              sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
  end

  // Leading zeros from bit MAG_W; highest set bit wins as the loop ascends
  always_comb begin
    lzc_d = LZC_W'(MAG_W + 1);
    for (int i = 0; i <= int'(MAG_W); i++) begin
      if (sum_d[i]) lzc_d = LZC_W'(int'(MAG_W) - i);
    end
  end

  // Stage 2 register: result and flags, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      sign_q     <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b1;
      lzc_q      <= LZC_W'(MAG_W + 1);
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q   <= sum_d;
        // Zero result is always +0
        sign_q  <= (sum_d == '0) ? 1'b0 : s1_sign_q;
        carry_q <= sum_d[MAG_W];
        zero_q  <= (sum_d == '0);
        lzc_q   <= lzc_d;
      end
    end
  end

  // Saturating count of delivered carry beats; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (fire && carry_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Output drive
  always_comb begin
    in_ready  = s1_en;
    out_valid = s2_valid_q;
    res       = res_q;
    sign_res  = sign_q;
    carry     = carry_q;
    zero      = zero_q;
    lzc       = lzc_q;
    carry_cnt = cnt_q;
  end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Randomised and directed bench for sm_addsub_pipe, checked against a
// signed-integer reference model and an output scoreboard queue.
module tb_sm_addsub_pipe;
  localparam int MAG_W = 24;
  localparam int CNT_W = 2;
  localparam int LZC_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic op = 1'b0, sign_a = 1'b0, sign_b = 1'b0;
  logic [MAG_W-1:0] a = '0, b = '0;
  logic out_valid, out_ready = 1'b0;
  logic [MAG_W:0] res;
  logic sign_res, carry, zero;
  logic [LZC_W-1:0] lzc;
  logic clr_cnt = 1'b0;
  logic [CNT_W-1:0] carry_cnt;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .sign_a(sign_a), .sign_b(sign_b), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .sign_res(sign_res), .carry(carry), .zero(zero),
    .lzc(lzc), .clr_cnt(clr_cnt), .carry_cnt(carry_cnt)
  );

  typedef struct {
    logic [MAG_W:0]   res;
    logic             sign;
    logic             carry;
    logic             zero;
    logic [LZC_W-1:0] lzc;
  } exp_t;

  typedef struct {
    logic op, sa, sb;
    logic [MAG_W-1:0] a, b;
  } beat_t;

  exp_t  q[$];
  beat_t pend[$];
  int    n_vec = 0, n_err = 0;
  int    cnt_m = 0;
  bit    last_acc, last_drn;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic, then split into sign/magnitude
  function automatic exp_t model(input beat_t t);
    exp_t   e;
    longint va, vb, r, mag;
    int     n;
    va = t.sa ? -longint'(t.a) : longint'(t.a);
    vb = (t.sb ^ t.op) ? -longint'(t.b) : longint'(t.b);
    r = va + vb;
    mag = (r < 0) ? -r : r;
    e.res = mag[MAG_W:0];
    e.sign = (r < 0);
    e.carry = (mag >= (64'd1 << MAG_W));
    e.zero = (mag == 0);
    n = 0;
    while (n < MAG_W + 1 && !mag[MAG_W - n]) n++;
    e.lzc = LZC_W'(n);
    return e;
  endfunction

  // One clock: inputs already driven after the falling edge
  task automatic tick();
    exp_t  h;
    beat_t cur;
    #1;
    check("carry_cnt", carry_cnt, cnt_m);
    if (q.size() == 0) begin
      check("out_valid_idle", out_valid, 0);
    end else if (out_valid) begin
      h = q[0];
      check("res", res, h.res);
      check("sign_res", sign_res, h.sign);
      check("carry", carry, h.carry);
      check("zero", zero, h.zero);
      check("lzc", lzc, h.lzc);
    end
    last_acc = in_valid && in_ready;
    last_drn = out_valid && out_ready;
    if (clr_cnt) cnt_m = 0;
    else if (last_drn && q.size() != 0 && q[0].carry && cnt_m < (1 << CNT_W) - 1) cnt_m++;
    if (last_drn && q.size() != 0) void'(q.pop_front());
    if (last_acc) begin
      cur.op = op; cur.sa = sign_a; cur.sb = sign_b; cur.a = a; cur.b = b;
      q.push_back(model(cur));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (pend.size() != 0) begin
        in_valid = 1'b1;
        op = pend[0].op; sign_a = pend[0].sa; sign_b = pend[0].sb;
        a = pend[0].a; b = pend[0].b;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (last_acc) void'(pend.pop_front());
    end
  endtask

  function automatic beat_t mk(input logic o, input logic x, input logic y,
                               input logic [MAG_W-1:0] p, input logic [MAG_W-1:0] r);
    beat_t t;
    t.op = o; t.sa = x; t.sb = y; t.a = p; t.b = r;
    return t;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t t;
    int sel;
    t.op = 1'($urandom); t.sa = 1'($urandom); t.sb = 1'($urandom);
    t.a = MAG_W'($urandom); t.b = MAG_W'($urandom);
    sel = $urandom_range(0, 5);
    if (sel == 0) t.b = t.a;
    else if (sel == 1) begin t.a = '1; t.b = MAG_W'($urandom) | 24'h800000; end
    else if (sel == 2) begin t.a = MAG_W'($urandom_range(0, 15)); t.b = MAG_W'($urandom_range(0, 15)); end
    return t;
  endfunction

  task automatic directed(input beat_t t, input logic [MAG_W:0] r, input logic s,
                          input logic c, input logic z, input logic [LZC_W-1:0] l);
    out_ready = 1'b1;
    pend.push_back(t);
    run(1);
    check("lat_cycle1", out_valid, 0);
    run(1);
    check("lat_cycle2", out_valid, 1);
    check("dir_res", res, r);
    check("dir_sign", sign_res, s);
    check("dir_carry", carry, c);
    check("dir_zero", zero, z);
    check("dir_lzc", lzc, l);
    run(1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (q.size() != 0 || pend.size() != 0); i++) run(1);
    check("drain_empty", q.size() + pend.size(), 0);
  endtask

  initial begin
    int acc_stall, k;
    logic [CNT_W-1:0] seq[6];
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_sign", sign_res, 0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 1);
    check("rst_lzc", lzc, MAG_W + 1);
    check("rst_cnt", carry_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Directed arithmetic cases
    directed(mk(0, 0, 0, 24'h800000, 24'h800000), 25'h1000000, 0, 1, 0, 0);
    directed(mk(1, 0, 0, 24'd5, 24'd9), 25'd4, 1, 0, 0, 22);
    directed(mk(0, 1, 0, 24'h123456, 24'h123456), 25'd0, 0, 0, 1, 25);
    directed(mk(0, 1, 1, 24'h000100, 24'h000001), 25'h101, 1, 0, 0, 16);
    drain();

    // Stall: four beats against a blocked output
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pend.push_back(rnd_beat());
    acc_stall = 0;
    for (int i = 0; i < 6; i++) begin
      run(1);
      if (last_acc) acc_stall++;
    end
    check("stall_accepted", acc_stall, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b1;
    pend.push_back(rnd_beat());
    pend.push_back(rnd_beat());
    run(2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_zero", zero, 1);
    check("mid_rst_lzc", lzc, MAG_W + 1);
    q.delete();
    pend.delete();
    cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(1);
    check("post_rst_in_ready", in_ready, 1);
    run(3);

    // Saturating counter with clear racing the sixth carry beat
    seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    clr_cnt = 1'b1;
    run(1);
    clr_cnt = 1'b0;
    for (int i = 0; i < 6; i++) pend.push_back(mk(0, 0, 0, 24'hffffff, 24'hffffff));
    k = 0;
    for (int i = 0; i < 20 && k < 6; i++) begin
      clr_cnt = out_valid && (k == 5);
      run(1);
      if (last_drn) begin
        check("cnt_seq", carry_cnt, seq[k]);
        k++;
      end
    end
    clr_cnt = 1'b0;
    check("cnt_seq_done", k, 6);
    drain();

    // Random traffic with random back-pressure
    for (int i = 0; i < 1500; i++) begin
      if (pend.size() == 0 && $urandom_range(0, 2) != 0) pend.push_back(rnd_beat());
      out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt = ($urandom_range(0, 39) == 0);
      run(1);
    end
    clr_cnt = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
